// File: rtl/rr_seg_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter with 7-segment status.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rr_seg_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_COOL  = 2'd2
   } state_e;

   // Default maximum number of consecutive cycles a single grant may be held
   localparam int unsigned DEFAULT_TIMEOUT = 16;

   // Active-low segment patterns, bit7..bit0 = a,b,c,d,e,f,g,dp (dp kept off)
   localparam logic [7:0] SEG_DIGIT [10] = '{
      8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
      8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
   };

   // All segments off
   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/rr_seg_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: level-sensitive requests are held until granted; done releases a grant.
interface rr_seg_arbiter_if;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic [2:0] gnt_id;
   logic       timeout;

   // Requester side drives requests and sees grants
   modport master (
      output en, req, done,
      input  gnt, gnt_valid, gnt_id, timeout
   );

   // Arbiter side sees requests and drives grants
   modport slave (
      input  en, req, done,
      output gnt, gnt_valid, gnt_id, timeout
   );
endinterface

// File: rtl/seg7_dec.sv
// Decodes a 0..9 value into active-low 7-segment drive, or blank.
// Latency: purely combinational.
// Backpressure: none.
module seg7_dec
   import rr_seg_arbiter_pkg::*;
(
   input  logic [3:0] val_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   // Values above 9 have no digit glyph, so they show blank as well
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i && (val_i <= 4'd9)) begin
         seg_o = SEG_DIGIT[val_i];
      end
   end

endmodule

// File: rtl/rr_seg_arbiter.sv
// 8-way round-robin arbiter with hold timeout, cool-down cycle and 7-seg status.
// Latency: grant registered one cycle after a request is seen in IDLE.
// Backpressure: grant held until done, request drop or TIMEOUT; en only gates new grants.
module rr_seg_arbiter
   import rr_seg_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   rr_seg_arbiter_if.slave   arb,
   output logic [7:0]        o_seg0,
   output logic [7:0]        o_seg1,
   output logic [7:0]        o_seg2,
   output logic [7:0]        o_seg3,
   output logic [7:0]        o_seg4,
   output logic [7:0]        o_seg5,
   output logic [7:0]        o_seg6,
   output logic [7:0]        o_seg7
);

   state_e     state_q;
   logic [2:0] ptr_q;
   logic [7:0] timer_q;
   logic [3:0] cnt_q;
   logic [7:0] gnt_q;
   logic [2:0] gnt_id_q;
   logic       timeout_q;

   logic       pick_vld_d;
   logic [2:0] pick_id_d;
   logic       rel_norm_d;
   logic       tmo_hit_d;
   logic [3:0] cnt_d;

   // Scan upward from ptr with wrap; iterating from the far end lets the nearest hit win
   always_comb begin
      pick_vld_d = 1'b0;
      pick_id_d  = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         if (arb.req[ptr_q + 3'(i)]) begin
            pick_vld_d = 1'b1;
            pick_id_d  = ptr_q + 3'(i);
         end
      end
   end

   // Release conditions: done or request drop are normal and take precedence over expiry
   always_comb begin
      rel_norm_d = arb.done || !arb.req[gnt_id_q];
      tmo_hit_d  = (timer_q == 8'(TIMEOUT - 1));
      cnt_d      = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
   end

   // Arbiter FSM with all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         timer_q   <= 8'd0;
         cnt_q     <= 4'd0;
         gnt_q     <= 8'd0;
         gnt_id_q  <= 3'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb.en && pick_vld_d) begin
                  state_q  <= ST_GRANT;
                  gnt_q    <= 8'd1 << pick_id_d;
                  gnt_id_q <= pick_id_d;
                  timer_q  <= 8'd0;
                  cnt_q    <= cnt_d;
               end
            end
            ST_GRANT: begin
               if (rel_norm_d || tmo_hit_d) begin
                  state_q   <= ST_COOL;
                  gnt_q     <= 8'd0;
                  ptr_q     <= gnt_id_q + 3'd1;
                  timeout_q <= !rel_norm_d;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            ST_COOL: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign arb.gnt       = gnt_q;
   assign arb.gnt_valid = |gnt_q;
   assign arb.gnt_id    = gnt_id_q;
   assign arb.timeout   = timeout_q;

   seg7_dec u_seg_id (
      .val_i   ({1'b0, gnt_id_q}),
      .blank_i (~(|gnt_q)),
      .seg_o   (o_seg0)
   );

   seg7_dec u_seg_cnt (
      .val_i   (cnt_q),
      .blank_i (1'b0),
      .seg_o   (o_seg1)
   );

   assign o_seg2 = SEG_BLANK;
   assign o_seg3 = SEG_BLANK;
   assign o_seg4 = SEG_BLANK;
   assign o_seg5 = SEG_BLANK;
   assign o_seg6 = SEG_BLANK;
   assign o_seg7 = SEG_BLANK;

endmodule

// File: tb/tb_rr_seg_arbiter.sv
// Scoreboard bench for rr_seg_arbiter: stimulus queues expected grants, monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_rr_seg_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] seg [8];

   rr_seg_arbiter_if arb ();

   rr_seg_arbiter #(.TIMEOUT(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb    (arb),
      .o_seg0 (seg[0]),
      .o_seg1 (seg[1]),
      .o_seg2 (seg[2]),
      .o_seg3 (seg[3]),
      .o_seg4 (seg[4]),
      .o_seg5 (seg[5]),
      .o_seg6 (seg[6]),
      .o_seg7 (seg[7])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0] id;
      logic [7:0] seg1;
      int         len;    // 0 = length not checked
      bit         tmo;
      bit         abort;  // grant expected to be cut by reset
   } exp_t;

   exp_t exp_q[$];
   logic [7:0] dig [10];

   int  n_total  = 0;
   int  n_passed = 0;
   bit  in_grant = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (ok) n_passed++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
   endtask

   function automatic exp_t mk(input logic [2:0] id, input logic [7:0] s1, input int len,
                               input bit tmo, input bit abort);
      exp_t e;
      e.id = id; e.seg1 = s1; e.len = len; e.tmo = tmo; e.abort = abort;
      return e;
   endfunction

   // Monitor: samples on the falling edge, pops one expectation per grant
   initial begin
      exp_t cur;
      int   cur_len;
      int   gap;
      bit   seen_grant;
      cur = mk(3'd0, 8'h00, 0, 1'b0, 1'b0);
      cur_len = 0; gap = 0; seen_grant = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (in_grant) chk(cur.abort, "abort_by_reset", 32'(cur.abort), 32'd1);
            in_grant = 0; seen_grant = 0; gap = 0;
         end else if (arb.gnt_valid && !in_grant) begin
            if (seen_grant) chk(gap >= 1, "grant_gap", 32'(gap), 32'd1);
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_grant", 32'(arb.gnt), 32'd0);
               cur = mk(3'd0, 8'h00, 0, 1'b0, 1'b0);
            end else begin
               cur = exp_q.pop_front();
               chk(arb.gnt == (8'd1 << cur.id), "gnt_onehot", 32'(arb.gnt), 32'(8'd1 << cur.id));
               chk(arb.gnt_id == cur.id, "gnt_id", 32'(arb.gnt_id), 32'(cur.id));
               chk(seg[0] == dig[cur.id], "seg0_id", 32'(seg[0]), 32'(dig[cur.id]));
               chk(seg[1] == cur.seg1, "seg1_count", 32'(seg[1]), 32'(cur.seg1));
            end
            in_grant = 1; cur_len = 1;
         end else if (arb.gnt_valid) begin
            cur_len++;
            if (arb.timeout) chk(1'b0, "timeout_during_grant", 32'd1, 32'd0);
         end else if (in_grant) begin
            in_grant = 0; seen_grant = 1; gap = 1;
            if (cur.abort) chk(1'b0, "abort_expected", 32'd0, 32'd1);
            if (cur.len != 0) chk(cur_len == cur.len, "grant_len", 32'(cur_len), 32'(cur.len));
            chk(arb.timeout == cur.tmo, "timeout_pulse", 32'(arb.timeout), 32'(cur.tmo));
         end else begin
            gap++;
            if (arb.timeout) chk(1'b0, "spurious_timeout", 32'd1, 32'd0);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_level(input bit lvl, input int max, input string name);
      int t = 0;
      while (arb.gnt_valid != lvl && t < max) begin
         cyc(1);
         t++;
      end
      if (arb.gnt_valid != lvl) chk(1'b0, name, 32'(arb.gnt_valid), 32'(lvl));
   endtask

   // Wait for a grant, keep it for hold more cycles, then pulse done
   task automatic serve(input int hold);
      wait_level(1'b1, 50, "wait_grant");
      cyc(hold);
      arb.done = 1'b1;
      cyc(1);
      arb.done = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag, input logic [7:0] s1);
      chk(arb.gnt == 8'h00, {tag, "_gnt"}, 32'(arb.gnt), 32'h00);
      chk(arb.gnt_valid == 1'b0, {tag, "_gnt_valid"}, 32'(arb.gnt_valid), 32'd0);
      chk(arb.timeout == 1'b0, {tag, "_timeout"}, 32'(arb.timeout), 32'd0);
      chk(seg[0] == 8'hFF, {tag, "_seg0"}, 32'(seg[0]), 32'hFF);
      chk(seg[1] == s1, {tag, "_seg1"}, 32'(seg[1]), 32'(s1));
   endtask

   initial begin
      dig = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
      rst = 1'b1;
      arb.en = 1'b0; arb.req = 8'h00; arb.done = 1'b0;
      cyc(3);

      // Reset state
      chk_idle_outputs("reset", 8'h03);
      chk(arb.gnt_id == 3'd0, "reset_gnt_id", 32'(arb.gnt_id), 32'd0);
      for (int i = 2; i < 8; i++) chk(seg[i] == 8'hFF, "blank_digit", 32'(seg[i]), 32'hFF);
      rst = 1'b0;
      cyc(3);
      chk_idle_outputs("post_reset", 8'h03);

      // Round robin between requesters 0 and 7
      exp_q.push_back(mk(3'd0, 8'h9F, 3, 1'b0, 1'b0));
      exp_q.push_back(mk(3'd7, 8'h25, 3, 1'b0, 1'b0));
      exp_q.push_back(mk(3'd0, 8'h0D, 3, 1'b0, 1'b0));
      exp_q.push_back(mk(3'd7, 8'h99, 3, 1'b0, 1'b0));
      arb.en = 1'b1; arb.req = 8'h81;
      for (int k = 0; k < 4; k++) serve(2);
      arb.req = 8'h00;
      cyc(4);

      // Timeout on requester 2, then re-granted after cool-down
      exp_q.push_back(mk(3'd2, 8'h49, 16, 1'b1, 1'b0));
      exp_q.push_back(mk(3'd2, 8'h41, 4, 1'b0, 1'b0));
      arb.req = 8'h04;
      wait_level(1'b1, 20, "wait_tmo_grant");
      wait_level(1'b0, 40, "wait_tmo_release");
      serve(3);
      arb.req = 8'h00;
      cyc(4);

      // done coincides with timer expiry: normal release, no timeout
      exp_q.push_back(mk(3'd2, 8'h1F, 16, 1'b0, 1'b0));
      arb.req = 8'h04;
      serve(15);
      arb.req = 8'h00;
      cyc(4);

      // en dropped mid-grant: grant continues, no new grant afterwards
      exp_q.push_back(mk(3'd4, 8'h01, 6, 1'b0, 1'b0));
      arb.req = 8'h30;
      wait_level(1'b1, 20, "wait_en_grant");
      arb.en = 1'b0;
      serve(5);
      cyc(10);
      chk_idle_outputs("en_low", 8'h01);
      chk(arb.gnt_id == 3'd4, "gnt_id_hold", 32'(arb.gnt_id), 32'd4);

      // Reset mid-grant drops gnt asynchronously and clears the counter
      exp_q.push_back(mk(3'd5, 8'h09, 0, 1'b0, 1'b1));
      arb.en = 1'b1;
      wait_level(1'b1, 20, "wait_rst_grant");
      cyc(3);
      #2 rst = 1'b1;
      #1;
      chk_idle_outputs("async_rst", 8'h03);
      chk(arb.gnt_id == 3'd0, "async_rst_gnt_id", 32'(arb.gnt_id), 32'd0);
      arb.req = 8'h00;
      cyc(1);
      rst = 1'b0;
      cyc(3);
      chk(arb.timeout == 1'b0, "no_timeout_after_rst", 32'(arb.timeout), 32'd0);

      // Ten grants wrap the counter back to 0
      for (int k = 0; k < 10; k++)
         exp_q.push_back(mk(3'd0, dig[(k + 1) % 10], 1, 1'b0, 1'b0));
      arb.req = 8'h01;
      for (int k = 0; k < 10; k++) serve(0);
      arb.req = 8'h00;
      cyc(4);
      chk_idle_outputs("wrap", 8'h03);

      begin
         int t = 0;
         while ((exp_q.size() != 0 || in_grant) && t < 100) begin
            cyc(1);
            t++;
         end
      end
      chk(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/rr_seg_arbiter.md
RR_SEG_ARBITER -- requirements
Module: rr_seg_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of consecutive cycles one grant is held (legal range 2..255).
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port en, input, 1 bit: arbitration enable; when 0, no new grant is issued.
REQ-005 Port req, input, 8 bits: one request line per requester, level-sensitive.
REQ-006 Port done, input, 1 bit: the current grantee releases the resource.
REQ-007 Port gnt, output, 8 bits: one-hot grant, registered.
REQ-008 Port gnt_valid, output, 1 bit: a grant is active (equals OR of gnt).
REQ-009 Port gnt_id, output, 3 bits: binary index of the current or last grantee.
REQ-010 Port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by TIMEOUT.
REQ-011 Port o_seg0, output, 8 bits: active-low segments showing gnt_id, blank when gnt_valid=0.
REQ-012 Port o_seg1, output, 8 bits: active-low segments showing the grant counter (0..9).
REQ-013 Ports o_seg2..o_seg7, outputs, 8 bits each: constant blank (8'hFF).

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT and COOL.
REQ-015 In IDLE, when en=1 and req!=0, the block SHALL select the first set req bit found by scanning upward from ptr (wrapping 7->0), and enter GRANT with gnt set on the next edge (1-cycle latency).
REQ-016 In IDLE, when en=0 or req=0, the block SHALL remain in IDLE with gnt=0.
REQ-017 In GRANT, the block SHALL leave for COOL on the first of: done=1; req[gnt_id]=0; timer reaching TIMEOUT-1.
REQ-018 Release priority: done and req-drop are normal releases; timeout SHALL assert only when the timer expires in a cycle where neither done nor req-drop is present.
REQ-019 timer SHALL clear on GRANT entry and increment once per GRANT cycle.
REQ-020 On GRANT exit, ptr SHALL become gnt_id+1 modulo 8, so the served requester has lowest priority next.
REQ-021 COOL SHALL last exactly one cycle with gnt=0, then return to IDLE; consequently back-to-back grants are separated by at least one idle gnt cycle.
REQ-022 Clearing en during GRANT SHALL NOT revoke the current grant; it only blocks the next one.
REQ-023 The grant counter SHALL increment on every IDLE->GRANT transition and wrap 9->0.
REQ-024 gnt_id SHALL hold its last value through COOL and IDLE.
REQ-025 Segment bit order SHALL be bit7..bit0 = a,b,c,d,e,f,g,dp, active-low, with dp always off. Digit patterns: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex); blank=FF.
REQ-026 Segment outputs SHALL be combinational from registered state, with no extra latency.

Reset
REQ-027 While rst=1, the block SHALL set: state=IDLE, ptr=0, timer=0, counter=0, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, o_seg0=FF, o_seg1=03.
REQ-028 A reset asserted mid-GRANT SHALL drop gnt immediately (asynchronously), and no timeout pulse SHALL be produced.

Structure
REQ-029 The shared package SHALL hold the state enumeration, the ten digit patterns, the blank constant and the default TIMEOUT.
REQ-030 A sub-module seg7_dec (4-bit value plus blank in, 8-bit active-low segments out) SHALL be instantiated for o_seg0 and o_seg1.

Verification
REQ-031 Reset check: assert rst -> gnt=00, o_seg0=FF, o_seg1=03; release rst with req=00 -> outputs stay unchanged.
REQ-032 Round-robin: en=1, req=8'h81 held, done pulsed each grant -> grant sequence 0,7,0,7 with a gnt=0 cycle between each; o_seg1 steps 9F,25,0D,99.
REQ-033 Timeout: TIMEOUT=16, req=8'h04 held, done=0 -> gnt=04 for exactly 16 cycles, timeout pulses once, then one COOL cycle, then gnt=04 again.
REQ-034 Simultaneous events: done=1 in the same cycle the timer expires -> timeout stays 0, normal release.
REQ-035 Enable and reset interplay: en dropped mid-grant -> the grant continues until done, then none is issued; rst asserted mid-grant -> gnt=00 immediately, counter=0.
REQ-036 Counter wrap: 10 completed grants -> o_seg1 returns to 03.
